uart_tx_frame: RTL

Parametrised UART transmitter that serialises one word per frame onto `txd`, with configurable data width, stop-bit count, bit order and optional parity. Bit timing comes from an internal divider on the single system clock. A one-entry holding register, behind a valid/ready handshake, lets frames go out back-to-back with no idle gap. The block sits between the host-side byte source and the serial pin, and is the transmit half of the UART controller.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_tx_frame.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and line-level constants for the transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Reloadable bit-period down-counter; tick marks the last clk cycle of each bit.
module uart_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Self-reloads at zero so consecutive bits need no external load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load || (r_cnt == '0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign tick = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with one-word holding register; parity bit and parity_odd port
// exist only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int CLK_DIV   = 16,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 txd,
    output logic                 busy
);

    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic [DATA_BITS-1:0] r_hold;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_hold_full;
    logic                 r_ready;
    logic                 r_txd;
    logic                 r_busy;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 w_tick;
    logic                 w_accept;
    logic                 w_load_frame;
    logic                 w_last_stop;
    logic                 w_data_bit;
    logic                 w_txd_nxt;

`ifdef UART_TX_PARITY_EN
    logic r_hold_odd;
    logic r_par;

    function automatic logic f_parity(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ (odd == PAR_ODD);
    endfunction
`endif

    assign w_accept    = tx_valid && r_ready;
    assign w_last_stop = (r_stop_cnt == LAST_STOP);
    assign w_data_bit  = (MSB_FIRST != 0) ? r_shift[DATA_BITS-1] : r_shift[0];

    uart_baud_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .load(w_load_frame),
        .tick(w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_txd_nxt is the line level for the current state; r_txd presents it one cycle later.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_frame = 1'b0;
        w_txd_nxt    = STOP_BIT;
        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_load_frame = 1'b1;
                    w_state_nxt  = START;
                end
            end
            START: begin
                w_txd_nxt = START_BIT;
                if (w_tick) w_state_nxt = DATA;
            end
            DATA: begin
                w_txd_nxt = w_data_bit;
                if (w_tick && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                w_txd_nxt = r_par;
                if (w_tick) w_state_nxt = STOP;
            end
`endif
            STOP: begin
                w_txd_nxt = STOP_BIT;
                if (w_tick && w_last_stop) begin
                    if (r_hold_full) begin
                        w_load_frame = 1'b1;
                        w_state_nxt  = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Accept and transfer never coincide: r_ready is low whenever the holding register is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
            r_txd       <= STOP_BIT;
            r_busy      <= 1'b0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_full <= 1'b1;
            end else if (w_load_frame) begin
                r_hold_full <= 1'b0;
            end
            r_ready <= w_accept ? 1'b0 : !r_hold_full;
            r_txd   <= w_txd_nxt;
            r_busy  <= (r_state != IDLE);
            if (r_state == START) begin
                r_bit_cnt <= '0;
            end else if ((r_state == DATA) && w_tick) begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
            if (r_state != STOP) begin
                r_stop_cnt <= 1'b0;
            end else if (w_tick) begin
                r_stop_cnt <= r_stop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold <= tx_data;
`ifdef UART_TX_PARITY_EN
            r_hold_odd <= parity_odd;
`endif
        end
        if (w_load_frame) begin
            r_shift <= r_hold;
`ifdef UART_TX_PARITY_EN
            r_par <= f_parity(r_hold, r_hold_odd);
`endif
        end else if ((r_state == DATA) && w_tick) begin
            r_shift <= (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
        end
    end

    assign tx_ready = r_ready;
    assign txd      = r_txd;
    assign busy     = r_busy;

endmodule
